// File: rtl/st_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : st_dma_ctrl
// Purpose  : ST/STE DMA data path: byte FIFO, sector count, mode/status, RDY burst handshake.
// Revision : 1.0
// ============================================================================
module st_dma_ctrl #(
  parameter int FIFO_BYTES   = 16,   // power of two, >= 4
  parameter int SECTOR_BYTES = 512
) (
  input  logic        clk32,
  input  logic        resb,
  input  logic        clk_en,
  input  logic        FCS_N,
  input  logic        RW,
  input  logic        A1,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        RDY_I,
  output logic        RDY_O,
  input  logic        dev_wr,
  input  logic [7:0]  dev_din,
  input  logic        dev_rd,
  output logic [7:0]  dev_dout,
  output logic        dev_drq,
  output logic        cmd_wr,
  output logic [7:0]  cmd_data
);

  localparam int c_PTR_W   = $clog2(FIFO_BYTES);
  localparam int c_CNT_W   = $clog2(FIFO_BYTES + 1);
  localparam int c_WORDS   = FIFO_BYTES / 2;
  localparam int c_WCNT_W  = $clog2(c_WORDS);
  localparam int c_BCNT_W  = $clog2(SECTOR_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_armed;
  logic                  r_dir;
  logic                  r_scsel;
  logic [7:0]            r_sc;
  logic                  r_err;
  logic [c_BCNT_W-1:0]   r_byte_cnt;
  logic [c_WCNT_W-1:0]   r_word_cnt;
  logic                  r_rdy;
  logic                  r_cmd_wr;
  logic [7:0]            r_cmd_data;
  logic [7:0]            r_mem [FIFO_BYTES];
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic w_wr_stb, w_mode_wr, w_dir_chg, w_sc_wr, w_cmd_stb;
  logic w_empty, w_full, w_word, w_dev_push, w_dev_pop, w_dev_bad, w_sc_nz;
  logic [1:0] w_push_n, w_pop_n;
  logic [7:0] w_head, w_next;

  // One register write per FCS_N assertion; r_armed re-opens the window once FCS_N rises.
  assign w_wr_stb   = clk_en & ~FCS_N & ~RW & r_armed;
  assign w_mode_wr  = w_wr_stb & A1;
  assign w_dir_chg  = w_mode_wr & (DIN[8] != r_dir);
  assign w_sc_wr    = w_wr_stb & ~A1 & r_scsel;
  assign w_cmd_stb  = w_wr_stb & ~A1 & ~r_scsel;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_CNT_W'(FIFO_BYTES));
  assign w_sc_nz    = |r_sc;
  assign w_word     = (r_state == S_REQ) & clk_en & ~RDY_I;
  assign w_dev_push = dev_wr & ~r_dir & ~w_full;
  assign w_dev_pop  = dev_rd & r_dir & ~w_empty;
  assign w_dev_bad  = (dev_wr & (r_dir | w_full)) | (dev_rd & (~r_dir | w_empty));

  // Direction fixes which end each side owns, so each end has a single source per cycle.
  assign w_push_n   = r_dir ? (w_word ? 2'd2 : 2'd0) : (w_dev_push ? 2'd1 : 2'd0);
  assign w_pop_n    = r_dir ? (w_dev_pop ? 2'd1 : 2'd0) : (w_word ? 2'd2 : 2'd0);

  assign w_head     = r_mem[r_rd_ptr];
  assign w_next     = r_mem[r_rd_ptr + c_PTR_W'(1)];

  assign dev_dout   = w_empty ? 8'h00 : w_head;
  assign dev_drq    = w_sc_nz & (r_dir ? ~w_empty : ~w_full);
  assign RDY_O      = r_rdy;
  assign cmd_wr     = r_cmd_wr;
  assign cmd_data   = r_cmd_data;

  always_comb begin
    DOUT = 16'h0000;
    if (!FCS_N && RW) begin
      if (A1)
        DOUT = {13'b0, dev_drq, w_sc_nz, ~r_err};
      else if (r_scsel)
        DOUT = {8'h00, r_sc};
    end else if (!r_rdy && FCS_N && !r_dir) begin
      DOUT = {w_head, w_next};
    end
  end

  always_ff @(posedge clk32) begin
    if (w_dev_push)
      r_mem[r_wr_ptr] <= dev_din;
    if (w_word && r_dir) begin
      r_mem[r_wr_ptr]                <= DIN[15:8];
      r_mem[r_wr_ptr + c_PTR_W'(1)]  <= DIN[7:0];
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else if (w_dir_chg) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push_n);
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop_n);
      r_count  <= r_count + c_CNT_W'(w_push_n) - c_CNT_W'(w_pop_n);
      if (w_dev_bad)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_armed    <= 1'b1;
      r_dir      <= 1'b0;
      r_scsel    <= 1'b0;
      r_sc       <= 8'h00;
      r_byte_cnt <= '0;
      r_cmd_wr   <= 1'b0;
      r_cmd_data <= 8'h00;
    end else begin
      if (FCS_N)
        r_armed <= 1'b1;
      else if (w_wr_stb)
        r_armed <= 1'b0;
      if (w_mode_wr) begin
        r_dir   <= DIN[8];
        r_scsel <= DIN[4];
      end
      r_cmd_wr <= w_cmd_stb;
      if (w_cmd_stb)
        r_cmd_data <= DIN[7:0];
      if (w_sc_wr) begin
        r_sc       <= DIN[7:0];
        r_byte_cnt <= '0;
      end else if (w_dir_chg) begin
        r_byte_cnt <= '0;
      end else if (w_word) begin
        if (r_byte_cnt == c_BCNT_W'(SECTOR_BYTES - 2)) begin
          r_byte_cnt <= '0;
          if (w_sc_nz)
            r_sc <= r_sc - 8'd1;
        end else begin
          r_byte_cnt <= r_byte_cnt + c_BCNT_W'(2);
        end
      end
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_state    <= S_IDLE;
      r_rdy      <= 1'b1;
      r_word_cnt <= '0;
    end else if (w_dir_chg) begin
      r_state    <= S_IDLE;
      r_rdy      <= 1'b1;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sc_nz && (r_dir ? w_empty : w_full)) begin
            r_state    <= S_REQ;
            r_rdy      <= 1'b0;
            r_word_cnt <= '0;
          end
        end
        S_REQ: begin
          if (w_word) begin
            if (r_word_cnt == c_WCNT_W'(c_WORDS - 1)) begin
              r_state <= S_DONE;
              r_rdy   <= 1'b1;
            end else begin
              r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_st_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_st_dma_ctrl
// Purpose  : Directed self-checking bench for st_dma_ctrl.
// Revision : 1.0
// ============================================================================
module tb_st_dma_ctrl;

  logic        clk32 = 1'b0;
  logic        clk_en = 1'b0;
  logic        resb;
  logic        FCS_N, RW, A1;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic        RDY_I;
  logic        RDY_O;
  logic        dev_wr, dev_rd;
  logic [7:0]  dev_din, dev_dout;
  logic        dev_drq;
  logic        cmd_wr;
  logic [7:0]  cmd_data;

  int checks = 0;
  int errors = 0;
  int cmd_pulses = 0;

  st_dma_ctrl #(.FIFO_BYTES(16), .SECTOR_BYTES(512)) dut (
    .clk32(clk32), .resb(resb), .clk_en(clk_en),
    .FCS_N(FCS_N), .RW(RW), .A1(A1), .DIN(DIN), .DOUT(DOUT),
    .RDY_I(RDY_I), .RDY_O(RDY_O),
    .dev_wr(dev_wr), .dev_din(dev_din), .dev_rd(dev_rd), .dev_dout(dev_dout),
    .dev_drq(dev_drq), .cmd_wr(cmd_wr), .cmd_data(cmd_data)
  );

  always #5 clk32 = ~clk32;
  // Bus phase: every other clk32 edge is a clk_en edge.
  always @(posedge clk32) clk_en <= ~clk_en;
  always @(negedge clk32) if (cmd_wr === 1'b1) cmd_pulses++;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_en();
    do @(negedge clk32); while (clk_en !== 1'b1);
  endtask

  task automatic reg_write(input logic a1, input logic [15:0] d);
    wait_en();
    FCS_N = 1'b0; RW = 1'b0; A1 = a1; DIN = d;
    @(negedge clk32);
    FCS_N = 1'b1; RW = 1'b1;
  endtask

  task automatic reg_read(input logic a1, output logic [15:0] d);
    FCS_N = 1'b0; RW = 1'b1; A1 = a1;
    #1 d = DOUT;
    FCS_N = 1'b1;
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    dev_wr = 1'b1; dev_din = b;
    @(negedge clk32);
    dev_wr = 1'b0;
  endtask

  task automatic pop(output logic [7:0] b);
    b = dev_dout; dev_rd = 1'b1;
    @(negedge clk32);
    dev_rd = 1'b0;
  endtask

  task automatic mcu_word(input logic [15:0] wd, output logic [15:0] rd);
    wait_en();
    RDY_I = 1'b0; DIN = wd;
    #1 rd = DOUT;
    @(negedge clk32);
    RDY_I = 1'b1;
  endtask

  task automatic wait_rdy_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk32);
      if (RDY_O === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  b;
    bit          ok;
    int          bad, tmo, p0;

    resb = 1'b0; FCS_N = 1'b1; RW = 1'b1; A1 = 1'b0; DIN = 16'h0;
    RDY_I = 1'b1; dev_wr = 1'b0; dev_rd = 1'b0; dev_din = 8'h0;
    repeat (4) @(negedge clk32);
    resb = 1'b1;
    @(negedge clk32);

    check("rst_rdy_o", {15'b0, RDY_O}, 16'h0001);
    check("rst_dout", DOUT, 16'h0000);
    check("rst_dev_dout", {8'b0, dev_dout}, 16'h0000);
    check("rst_dev_drq", {15'b0, dev_drq}, 16'h0000);
    check("rst_cmd", {7'b0, cmd_wr, cmd_data}, 16'h0000);
    reg_read(1'b1, rd);
    check("rst_status", rd, 16'h0001);

    // Disk -> RAM, one burst
    reg_write(1'b1, 16'h0010);
    reg_write(1'b0, 16'h0001);
    reg_read(1'b0, rd);
    check("sc_readback", rd, 16'h0001);
    reg_write(1'b1, 16'h0000);
    reg_read(1'b1, rd);
    check("status_d2r_armed", rd, 16'h0007);
    for (int j = 0; j < 16; j++) push(8'(j));
    check("rdy_before_req", {15'b0, RDY_O}, 16'h0001);
    @(negedge clk32);
    check("rdy_req_full", {15'b0, RDY_O}, 16'h0000);
    check("drq_full", {15'b0, dev_drq}, 16'h0000);
    for (int w = 0; w < 8; w++) begin
      mcu_word(16'h0, rd);
      check($sformatf("d2r_word%0d", w), rd, {8'(2*w), 8'(2*w+1)});
      if (w == 6) check("rdy_mid_burst", {15'b0, RDY_O}, 16'h0000);
    end
    check("rdy_after_burst", {15'b0, RDY_O}, 16'h0001);

    // Remaining 31 bursts finish the 512-byte sector
    bad = 0; tmo = 0;
    for (int k = 1; k < 32; k++) begin
      for (int j = 0; j < 16; j++) push(8'(k*16 + j));
      wait_rdy_low(ok);
      if (!ok) tmo++;
      for (int w = 0; w < 8; w++) begin
        mcu_word(16'h0, rd);
        if (rd !== {8'(k*16 + 2*w), 8'(k*16 + 2*w + 1)}) bad++;
      end
    end
    check("sector_timeouts", 16'(tmo), 16'h0000);
    check("sector_words", 16'(bad), 16'h0000);
    repeat (2) @(negedge clk32);
    reg_read(1'b1, rd);
    check("status_sc_zero", rd, 16'h0001);
    check("drq_sc_zero", {15'b0, dev_drq}, 16'h0000);
    for (int j = 0; j < 16; j++) push(8'hC0 + 8'(j));
    repeat (10) @(negedge clk32);
    check("no_req_sc_zero", {15'b0, RDY_O}, 16'h0001);

    // Overflow error, then direction change flush
    push(8'hEE);
    reg_read(1'b1, rd);
    check("status_overflow", rd, 16'h0000);
    reg_write(1'b1, 16'h0110);
    reg_read(1'b1, rd);
    check("status_flushed", rd, 16'h0001);
    check("dev_dout_flushed", {8'b0, dev_dout}, 16'h0000);

    // RAM -> disk
    reg_write(1'b0, 16'h0002);
    @(negedge clk32);
    check("rdy_r2d_req", {15'b0, RDY_O}, 16'h0000);
    for (int w = 0; w < 8; w++) mcu_word(16'hA1B2, rd);
    check("rdy_r2d_done", {15'b0, RDY_O}, 16'h0001);
    @(negedge clk32);
    reg_read(1'b1, rd);
    check("status_r2d_full", rd, 16'h0007);
    for (int j = 0; j < 16; j++) begin
      pop(b);
      check($sformatf("r2d_byte%0d", j), {8'b0, b}, (j % 2 == 0) ? 16'h00A1 : 16'h00B2);
    end
    @(negedge clk32);
    check("rdy_r2d_rereq", {15'b0, RDY_O}, 16'h0000);
    check("drq_r2d_empty", {15'b0, dev_drq}, 16'h0000);

    // Asynchronous reset in the middle of a request
    #2 resb = 1'b0;
    #1;
    check("midreq_rst_rdy", {15'b0, RDY_O}, 16'h0001);
    check("midreq_rst_drq", {15'b0, dev_drq}, 16'h0000);
    reg_read(1'b1, rd);
    check("midreq_rst_status", rd, 16'h0001);
    @(negedge clk32);
    resb = 1'b1;

    // Command pass-through
    reg_write(1'b1, 16'h0000);
    p0 = cmd_pulses;
    reg_write(1'b0, 16'h0080);
    repeat (2) @(negedge clk32);
    check("cmd_pulse_count", 16'(cmd_pulses - p0), 16'h0001);
    check("cmd_data_80", {8'b0, cmd_data}, 16'h0080);
    p0 = cmd_pulses;
    wait_en();
    FCS_N = 1'b0; RW = 1'b0; A1 = 1'b0; DIN = 16'h0055;
    repeat (6) @(negedge clk32);
    FCS_N = 1'b1; RW = 1'b1;
    repeat (3) @(negedge clk32);
    check("cmd_hold_count", 16'(cmd_pulses - p0), 16'h0001);
    check("cmd_data_55", {8'b0, cmd_data}, 16'h0055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
